// File: rtl/mbr_xfer_ctl.sv
// ---------------------------------------------------------------------------
// mbr_xfer_ctl
//   Memory buffer register with a built-in single-word memory transfer
//   controller. It holds one data word between the CPU internal bus and the
//   memory port. It runs one read or write at a time over a req/ack handshake,
//   and aborts with err when no ack arrives within TIMEOUT request cycles.
//
// Parameters
//   WIDTH    data word width in bits
//   TIMEOUT  maximum number of cycles mem_req stays high waiting for mem_ack
//            (must be >= 2)
//
// Ports
//   clk        rising-edge clock (single domain)
//   reset      synchronous, active-high reset
//   clr        clear the held word (IDLE only, has priority over bus_load)
//   bus_in     word from the internal bus
//   bus_load   load bus_in into the held word (IDLE only)
//   rd_start   start a memory read into the held word (IDLE only)
//   wr_start   start a memory write of the held word (IDLE only, wins over rd)
//   mbr_out    held word
//   mem_req    memory request (registered)
//   mem_we     1 = write, 0 = read; meaningful while mem_req = 1 (registered)
//   mem_wdata  write data, always equal to mbr_out
//   mem_rdata  read data, captured in the cycle mem_ack = 1 during a read
//   mem_ack    memory acknowledge, only looked at while a request is pending
//   busy       high while a transaction is pending
//   done       one-cycle pulse when a transaction ends (ack or timeout)
//   err        set on timeout; held until the next accepted start or reset
// ---------------------------------------------------------------------------
module mbr_xfer_ctl #(
  parameter int WIDTH   = 10,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             bus_load,
  input  logic             rd_start,
  input  logic             wr_start,
  output logic [WIDTH-1:0] mbr_out,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;

  // Value of count during the last request cycle before the timeout fires.
  // count is 0 in the first request cycle, so this keeps mem_req high for
  // exactly TIMEOUT cycles.
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q;

  // The write data path is the held word itself, so a bus_load issued
  // together with wr_start writes the freshly loaded word.
  assign mbr_out   = q;
  assign mem_wdata = q;

  // NOTE: every register here is written with non-blocking assignments so
  // that all of them update together at the edge, using pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // A reset in the middle of a transaction simply drops the request;
      // any ack arriving in the same cycle is discarded and no done pulse
      // is produced.
      state   <= IDLE;
      count   <= '0;
      q       <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      // done is a pulse: it is only raised by the transaction-ending
      // branches below and falls again on the following edge.
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (clr) begin
            q <= '0;
          end else if (bus_load) begin
            q <= bus_in;
          end

          if (wr_start || rd_start) begin
            state   <= wr_start ? WR_WAIT : RD_WAIT;
            mem_req <= 1'b1;
            mem_we  <= wr_start;
            busy    <= 1'b1;
            err     <= 1'b0;
            count   <= '0;
          end
        end

        RD_WAIT, WR_WAIT: begin
          // Bus-side controls are ignored here; the held word only changes
          // when a read is acknowledged. An ack in the final request cycle
          // takes precedence over the timeout.
          if (mem_ack) begin
            if (state == RD_WAIT) begin
              q <= mem_rdata;
            end
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            count   <= '0;
          end else if (count == LAST_CNT) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            count   <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end

        default: begin
          // Unreachable encoding: recover to a quiet IDLE.
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
          count   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbr_xfer_ctl.sv
// ---------------------------------------------------------------------------
// tb_mbr_xfer_ctl
//   Self-checking bench for mbr_xfer_ctl (WIDTH=10, TIMEOUT=15). Each cycle
//   record carries the inputs for one cycle and the outputs required after
//   the following rising edge; expectations go through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_mbr_xfer_ctl;

  localparam int W  = 10;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         clr;
  logic [W-1:0] bus_in;
  logic         bus_load;
  logic         rd_start;
  logic         wr_start;
  logic [W-1:0] mbr_out;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         mem_ack;
  logic         busy;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  mbr_xfer_ctl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .bus_in    (bus_in),
    .bus_load  (bus_load),
    .rd_start  (rd_start),
    .wr_start  (wr_start),
    .mbr_out   (mbr_out),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic         rst, clr, ld, rd, wr, ack;
    logic [W-1:0] din, rdata;
    logic [W-1:0] q;
    logic         req, we, busy, done, err;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic         req, we, busy, done, err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(
    input logic rst, input logic c, input logic ld, input logic [W-1:0] din,
    input logic rd, input logic wr, input logic ack, input logic [W-1:0] rdata,
    input logic [W-1:0] q, input logic req, input logic we, input logic bsy,
    input logic dn, input logic er);
    vec_t v;
    v.rst = rst; v.clr = c; v.ld = ld; v.din = din; v.rd = rd; v.wr = wr;
    v.ack = ack; v.rdata = rdata; v.q = q; v.req = req; v.we = we;
    v.busy = bsy; v.done = dn; v.err = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h  {q,wdata,req,we,busy,done,err}",
               name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, then compare the
  // registered outputs 1 time unit after the edge.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    logic [31:0] act, req_v;
    reset    = v.rst;
    clr      = v.clr;
    bus_load = v.ld;
    bus_in   = v.din;
    rd_start = v.rd;
    wr_start = v.wr;
    mem_ack  = v.ack;
    mem_rdata = v.rdata;
    sb.push_back('{q: v.q, req: v.req, we: v.we, busy: v.busy,
                   done: v.done, err: v.err});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    // mem_we only carries meaning while a request is expected.
    act   = {7'd0, mbr_out, mem_wdata, mem_req, mem_we & e.req, busy, done, err};
    req_v = {7'd0, e.q, e.q, e.req, e.we & e.req, e.busy, e.done, e.err};
    check(name, act, req_v);
  endtask

  vec_t tbl[18];

  initial begin
    // Main-function table; rows run back to back.
    //            rst clr ld din     rd wr ack rdata    q       req we bsy dn er
    tbl[0]  = mk(0, 0, 1, 10'h2A5, 0, 0, 0, 10'h000, 10'h2A5, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 10'h000, 0, 1, 0, 10'h000, 10'h2A5, 1, 1, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 10'h2A5, 1, 1, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 10'h2A5, 1, 1, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 10'h000, 0, 0, 1, 10'h3FF, 10'h2A5, 0, 0, 0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 10'h2A5, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 10'h000, 1, 0, 0, 10'h000, 10'h2A5, 1, 0, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 10'h000, 0, 0, 1, 10'h1C3, 10'h1C3, 0, 0, 0, 1, 0);
    tbl[8]  = mk(0, 0, 0, 10'h000, 0, 0, 0, 10'h2FF, 10'h1C3, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 10'h155, 1, 1, 0, 10'h000, 10'h155, 1, 1, 1, 0, 0);
    tbl[10] = mk(0, 0, 1, 10'h0F0, 0, 0, 0, 10'h000, 10'h155, 1, 1, 1, 0, 0);
    tbl[11] = mk(0, 1, 0, 10'h000, 0, 0, 0, 10'h000, 10'h155, 1, 1, 1, 0, 0);
    tbl[12] = mk(0, 0, 0, 10'h000, 1, 0, 1, 10'h3FF, 10'h155, 0, 0, 0, 1, 0);
    tbl[13] = mk(0, 0, 0, 10'h000, 0, 1, 0, 10'h000, 10'h155, 1, 1, 1, 0, 0);
    tbl[14] = mk(0, 0, 0, 10'h000, 0, 0, 1, 10'h222, 10'h155, 0, 0, 0, 1, 0);
    tbl[15] = mk(0, 1, 0, 10'h000, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 1, 1, 10'h003, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0);
    tbl[17] = mk(0, 0, 1, 10'h3AA, 0, 0, 0, 10'h000, 10'h3AA, 0, 0, 0, 0, 0);

    // Reset for two cycles with random inputs: everything comes up zero.
    for (int i = 0; i < 2; i++) begin
      apply(mk(1, 1'($urandom), 1'($urandom), W'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), W'($urandom),
               10'h000, 0, 0, 0, 0, 0), "reset");
    end

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i], $sformatf("table[%0d]", i));
    end

    // Timeout: no ack keeps mem_req high for exactly TO cycles, bus-side
    // controls are ignored throughout, then err and done rise together.
    apply(mk(0, 0, 0, 10'h000, 1, 0, 0, 10'h000, 10'h3AA, 1, 0, 1, 0, 0),
          "to_start");
    for (int i = 1; i < TO; i++) begin
      apply(mk(0, 1'($urandom), 1, W'($urandom), 1'($urandom), 1'($urandom),
               0, W'($urandom), 10'h3AA, 1, 0, 1, 0, 0),
            $sformatf("to_wait[%0d]", i));
    end
    apply(mk(0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 10'h3AA, 0, 0, 0, 1, 1),
          "to_expire");
    apply(mk(0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 10'h3AA, 0, 0, 0, 0, 1),
          "err_held");
    apply(mk(0, 0, 0, 10'h000, 0, 1, 0, 10'h000, 10'h3AA, 1, 1, 1, 0, 0),
          "err_cleared_by_wr");
    apply(mk(0, 0, 0, 10'h000, 0, 0, 1, 10'h000, 10'h3AA, 0, 0, 0, 1, 0),
          "wr_ack");

    // Ack in the final (TO-th) request cycle completes normally.
    apply(mk(0, 0, 0, 10'h000, 1, 0, 0, 10'h000, 10'h3AA, 1, 0, 1, 0, 0),
          "last_start");
    for (int i = 1; i < TO; i++) begin
      apply(mk(0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 10'h3AA, 1, 0, 1, 0, 0),
            $sformatf("last_wait[%0d]", i));
    end
    apply(mk(0, 0, 0, 10'h000, 0, 0, 1, 10'h0C7, 10'h0C7, 0, 0, 0, 1, 0),
          "last_ack");

    // Reset in the 4th RD_WAIT cycle, with ack in that same cycle.
    apply(mk(0, 0, 0, 10'h000, 1, 0, 0, 10'h000, 10'h0C7, 1, 0, 1, 0, 0),
          "rst_rd_start");
    for (int i = 1; i < 4; i++) begin
      apply(mk(0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 10'h0C7, 1, 0, 1, 0, 0),
            $sformatf("rst_rd_wait[%0d]", i));
    end
    apply(mk(1, 0, 0, 10'h000, 0, 0, 1, 10'h111, 10'h000, 0, 0, 0, 0, 0),
          "rst_with_ack");
    apply(mk(0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0),
          "after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
